// File: rtl/lz77_pkg.sv
// Shared LZ77 definitions used by the encoder and the matching decoder.
package lz77_pkg;

   localparam int SEARCH_DEPTH = 9;
   localparam int LOOK_DEPTH   = 8;
   localparam int CHAR_W       = 8;
   localparam int POS_W        = 4;
   localparam int LEN_W        = 3;
   localparam logic [CHAR_W-1:0] EOS_CHAR = 8'h24;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      EMIT = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [POS_W-1:0]  pos;
      logic [LEN_W-1:0]  len;
      logic [CHAR_W-1:0] chr;
   } triple_t;

endpackage

// File: rtl/lz77_match_finder.sv
// Combinational longest-match search over history and look-ahead, allowing
// matches that run into the look-ahead itself; ties resolve to the smallest pos.
module lz77_match_finder
   import lz77_pkg::*;
(
   input  logic [SEARCH_DEPTH-1:0][CHAR_W-1:0] hist,
   input  logic [LOOK_DEPTH-1:0][CHAR_W-1:0]   la,
   input  logic [3:0]                          hist_cnt,
   input  logic [3:0]                          la_cnt,
   output triple_t                             best
);

   localparam int MAXL = LOOK_DEPTH - 1;

   logic [LEN_W-1:0] cap;
   logic [LEN_W-1:0] run_len [SEARCH_DEPTH];
   logic [LEN_W-1:0] best_len;
   logic [POS_W-1:0] best_pos;

   // Cap keeps at least one look-ahead char free to serve as the literal.
   always_comb begin
      cap = '0;
      if (la_cnt == 4'd0)
         cap = '0;
      else if (la_cnt > 4'(MAXL))
         cap = LEN_W'(MAXL);
      else
         cap = LEN_W'(la_cnt - 4'd1);
   end

   genvar gp, gi;
   generate
      for (gp = 0; gp < SEARCH_DEPTH; gp++) begin : g_pos
         logic [MAXL-1:0]  eq;
         logic [LEN_W-1:0] len_p;
         logic             stop;
         for (gi = 0; gi < MAXL; gi++) begin : g_cmp
            if (gi <= gp) begin : g_hist
               assign eq[gi] = (la[gi] == hist[gp-gi]);
            end else begin : g_self
               assign eq[gi] = (la[gi] == la[gi-gp-1]);
            end
         end
         always_comb begin
            len_p = '0;
            stop  = 1'b0;
            for (int i = 0; i < MAXL; i++) begin
               if (!stop && eq[i] && (i < int'(cap)))
                  len_p = len_p + LEN_W'(1);
               else
                  stop = 1'b1;
            end
         end
         assign run_len[gp] = len_p;
      end
   endgenerate

   always_comb begin
      best_len = '0;
      best_pos = '0;
      for (int p = 0; p < SEARCH_DEPTH; p++) begin
         if ((p < int'(hist_cnt)) && (run_len[p] > best_len)) begin
            best_len = run_len[p];
            best_pos = POS_W'(p);
         end
      end
      best.pos = best_pos;
      best.len = best_len;
      best.chr = la[best_len];
   end

endmodule

// File: rtl/lz77_encoder.sv
// LZ77 encoder: buffers look-ahead, emits (pos,len,char) triples held for len+1 cycles.
// Optional triple counter port enabled by defining LZ77_STATS_EN.
module lz77_encoder
   import lz77_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CHAR_W-1:0] in_char,
   output logic              encode,
   output logic [POS_W-1:0]  code_pos,
   output logic [LEN_W-1:0]  code_len,
   output logic [CHAR_W-1:0] chardata,
   output logic              finish
`ifdef LZ77_STATS_EN
   ,output logic [15:0]      triple_cnt
`endif
);

   state_t                              state_reg;
   logic [SEARCH_DEPTH-1:0][CHAR_W-1:0] hist_reg;
   logic [LOOK_DEPTH-1:0][CHAR_W-1:0]   la_reg;
   logic [3:0]                          hist_cnt_reg;
   logic [3:0]                          la_cnt_reg;
   logic                                eos_seen_reg;
   logic [LEN_W-1:0]                    emit_cnt_reg;
   triple_t                             best;
   logic                                launch;

   lz77_match_finder u_match (
      .hist     (hist_reg),
      .la       (la_reg),
      .hist_cnt (hist_cnt_reg),
      .la_cnt   (la_cnt_reg),
      .best     (best)
   );

   assign launch = (la_cnt_reg == 4'(LOOK_DEPTH)) || (eos_seen_reg && (la_cnt_reg != 4'd0));

   // in_ready is registered as the value the next state will present, so it
   // reads 0 for one cycle after reset and never overlaps a launch.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= FILL;
         hist_reg     <= '0;
         la_reg       <= '0;
         hist_cnt_reg <= '0;
         la_cnt_reg   <= '0;
         eos_seen_reg <= 1'b0;
         emit_cnt_reg <= '0;
         in_ready     <= 1'b0;
         encode       <= 1'b0;
         finish       <= 1'b0;
         code_pos     <= '0;
         code_len     <= '0;
         chardata     <= '0;
`ifdef LZ77_STATS_EN
         triple_cnt   <= '0;
`endif
      end else begin
         case (state_reg)
            FILL: begin
               if (in_valid && in_ready) begin
                  la_reg[la_cnt_reg[2:0]] <= in_char;
                  la_cnt_reg <= la_cnt_reg + 4'd1;
                  if (in_char == EOS_CHAR)
                     eos_seen_reg <= 1'b1;
                  in_ready <= (la_cnt_reg < 4'(LOOK_DEPTH-1)) && (in_char != EOS_CHAR);
               end else if (launch) begin
                  code_pos     <= best.pos;
                  code_len     <= best.len;
                  chardata     <= best.chr;
                  emit_cnt_reg <= best.len;
                  encode       <= 1'b1;
                  in_ready     <= 1'b0;
                  state_reg    <= EMIT;
`ifdef LZ77_STATS_EN
                  if (triple_cnt != 16'hFFFF)
                     triple_cnt <= triple_cnt + 16'd1;
`endif
               end else if (eos_seen_reg && (la_cnt_reg == 4'd0)) begin
                  finish    <= 1'b1;
                  in_ready  <= 1'b0;
                  state_reg <= DONE;
               end else begin
                  in_ready <= (la_cnt_reg < 4'(LOOK_DEPTH)) && !eos_seen_reg;
               end
            end
            EMIT: begin
               hist_reg   <= {hist_reg[SEARCH_DEPTH-2:0], la_reg[0]};
               la_reg     <= {CHAR_W'(0), la_reg[LOOK_DEPTH-1:1]};
               la_cnt_reg <= la_cnt_reg - 4'd1;
               if (hist_cnt_reg != 4'(SEARCH_DEPTH))
                  hist_cnt_reg <= hist_cnt_reg + 4'd1;
               if (emit_cnt_reg == '0) begin
                  encode    <= 1'b0;
                  in_ready  <= !eos_seen_reg;
                  state_reg <= FILL;
               end else begin
                  emit_cnt_reg <= emit_cnt_reg - LEN_W'(1);
               end
            end
            DONE: begin
               finish   <= 1'b1;
               encode   <= 1'b0;
               in_ready <= 1'b0;
            end
            default: state_reg <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_lz77_encoder.sv
// Directed bench for lz77_encoder: feeds short streams and checks each triple,
// its hold time, backpressure and reset behaviour.
module tb_lz77_encoder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_char = 8'h00;
   logic       encode;
   logic [3:0] code_pos;
   logic [2:0] code_len;
   logic [7:0] chardata;
   logic       finish;
`ifdef LZ77_STATS_EN
   logic [15:0] triple_cnt;
`endif

   lz77_encoder dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_char  (in_char),
      .encode   (encode),
      .code_pos (code_pos),
      .code_len (code_len),
      .chardata (chardata),
      .finish   (finish)
`ifdef LZ77_STATS_EN
      ,.triple_cnt (triple_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] pos;
      logic [2:0] len;
      logic [7:0] chr;
      logic [7:0] cyc;
      logic       stable;
   } rec_t;

   rec_t       obs_q[$];
   rec_t       cur;
   logic       run_active = 1'b0;
   int         xfer_cnt = 0;
   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] stim[$];

   // Observer: counts accepted chars and records each encode run.
   always @(negedge clk) begin
      if (in_valid && in_ready)
         xfer_cnt++;
      if (encode) begin
         if (!run_active) begin
            run_active = 1'b1;
            cur = '{pos: code_pos, len: code_len, chr: chardata, cyc: 8'd1, stable: 1'b1};
         end else begin
            cur.cyc = cur.cyc + 8'd1;
            if ({code_pos, code_len, chardata} != {cur.pos, cur.len, cur.chr})
               cur.stable = 1'b0;
         end
      end else if (run_active) begin
         run_active = 1'b0;
         obs_q.push_back(cur);
         $display("triple pos=%0d len=%0d char=%02h cycles=%0d", cur.pos, cur.len, cur.chr, cur.cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("reset_outputs", {23'd0, encode, finish, in_ready, code_pos, code_len, chardata} & 32'h1FF_FFFF,
          32'd0);
      reset = 1'b0;
      @(negedge clk);
      obs_q.delete();
      xfer_cnt = 0;
   endtask

   task automatic feed();
      int  k = 0;
      int  cyc = 0;
      logic acc;
      while ((k < stim.size()) && (cyc < 500)) begin
         in_valid = 1'b1;
         in_char  = stim[k];
         acc      = in_ready;
         @(negedge clk);
         cyc++;
         if (acc) begin
            k++;
            if (k == 8)
               chk("full_backpressure", {31'd0, in_ready}, 32'd0);
         end
      end
      chk("feed_accepted", k, stim.size());
      in_char = 8'h5A;
   endtask

   task automatic wait_finish();
      int cyc = 0;
      while (!finish && (cyc < 300)) begin
         @(negedge clk);
         cyc++;
      end
      repeat (3) @(negedge clk);
      chk("finish", {31'd0, finish}, 32'd1);
      chk("done_in_ready", {31'd0, in_ready}, 32'd0);
      chk("done_encode", {31'd0, encode}, 32'd0);
      chk("no_accept_after_eos", xfer_cnt, stim.size());
   endtask

   task automatic exp_triple(input int idx, input logic [3:0] pos, input logic [2:0] len,
                             input logic [7:0] chr);
      rec_t got;
      rec_t want;
      want = '{pos: pos, len: len, chr: chr, cyc: 8'(len) + 8'd1, stable: 1'b1};
      got  = (idx < obs_q.size()) ? obs_q[idx] : '0;
      chk($sformatf("triple%0d", idx), {8'd0, got}, {8'd0, want});
   endtask

   initial begin
      int cyc;

      do_reset();

      // Run-length with self-overlapping match.
      stim = '{8'h41, 8'h41, 8'h41, 8'h41, 8'h24};
      feed();
      wait_finish();
      chk("count_aaaa", obs_q.size(), 2);
      exp_triple(0, 4'd0, 3'd0, 8'h41);
      exp_triple(1, 4'd0, 3'd3, 8'h24);

      do_reset();
      stim = '{8'h41, 8'h42, 8'h41, 8'h42, 8'h24};
      feed();
      wait_finish();
      chk("count_abab", obs_q.size(), 3);
      exp_triple(0, 4'd0, 3'd0, 8'h41);
      exp_triple(1, 4'd0, 3'd0, 8'h42);
      exp_triple(2, 4'd1, 3'd2, 8'h24);

      // Equal-length candidates at p=1 and p=3: smallest wins.
      do_reset();
      stim = '{8'h41, 8'h58, 8'h41, 8'h59, 8'h41, 8'h24};
      feed();
      wait_finish();
      chk("count_axaya", obs_q.size(), 4);
      exp_triple(0, 4'd0, 3'd0, 8'h41);
      exp_triple(1, 4'd0, 3'd0, 8'h58);
      exp_triple(2, 4'd1, 3'd1, 8'h59);
      exp_triple(3, 4'd1, 3'd1, 8'h24);

      do_reset();
      stim = '{8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h24};
      feed();
      wait_finish();
      chk("count_10a", obs_q.size(), 3);
      exp_triple(0, 4'd0, 3'd0, 8'h41);
      exp_triple(1, 4'd0, 3'd7, 8'h41);
      exp_triple(2, 4'd0, 3'd1, 8'h24);
`ifdef LZ77_STATS_EN
      chk("triple_cnt", {16'd0, triple_cnt}, 32'd3);
`endif

      // Abort a len=3 triple in its second emit cycle, then rerun cleanly.
      do_reset();
      stim = '{8'h41, 8'h41, 8'h41, 8'h41, 8'h24};
      feed();
      cyc = 0;
      while (!(encode && (code_len == 3'd3)) && (cyc < 100)) begin
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
      chk("emit_cycle2", {31'd0, encode}, 32'd1);
      do_reset();
      chk("abort_finish", {31'd0, finish}, 32'd0);
      feed();
      wait_finish();
      chk("count_rerun", obs_q.size(), 2);
      exp_triple(0, 4'd0, 3'd0, 8'h41);
      exp_triple(1, 4'd0, 3'd3, 8'h24);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
